// File: rtl/gato_clk_pkg.sv
// gato_clk_pkg: shared clock-divider controller types and divide constants
package gato_clk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam int DEFAULT_DIV_25MHZ = 2;
  localparam int DIV_1HZ = 50_000_000;
endpackage

// File: rtl/div_counter.sv
// div_counter: WIDTH-bit half-period counter with clear, enable and terminal-count flag
module div_counter
  import gato_clk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  assign tc = count == last;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : !en ? count : tc ? '0 : count + 1'b1;
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run-time programmable clock divider; new ratios take effect only at a half-period boundary
module freq_div_ctrl
  import gato_clk_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = DEFAULT_DIV_25MHZ
) (
  input  logic             C_100Mhz,
  input  logic             Reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);
  state_t state;
  logic [WIDTH-1:0] div_active, div_pend, count;
  logic cnt_tc, at_tc, xfer, legal;
  assign cfg_ready = state != PEND;
  assign running   = state != IDLE;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = xfer && cfg_div != '0;
  assign at_tc     = running && en && cnt_tc;
  div_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (C_100Mhz),
    .rst  (Reset),
    .clr  (!running || !en),
    .en   (1'b1),
    .last (div_active - 1'b1),
    .count(count),
    .tc   (cnt_tc)
  );
  // div_active only ever changes on an edge where the counter returns to 0
  always_ff @(posedge C_100Mhz or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      div_active <= WIDTH'(DEFAULT_DIV);
      div_pend   <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= xfer && cfg_div == '0;
      tick    <= at_tc;
      clk_out <= clk_out ^ at_tc;
      case (state)
        IDLE: begin
          if (legal) div_active <= cfg_div;
          if (en) state <= RUN;
        end
        RUN:
          if (!en) begin
            state <= IDLE;
            if (legal) div_active <= cfg_div;
          end else if (legal) begin
            state    <= PEND;
            div_pend <= cfg_div;
          end
        PEND:
          if (!en || at_tc) begin
            state      <= en ? RUN : IDLE;
            div_active <= div_pend;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Programmable controller for the system clock divider. It sequences the divide ratio at run time and generates the divided clock level (`clk_out`) plus a one-cycle tick enable.
- Sits between the game/VGA control logic (the configuring requester) and every consumer of the divided timebase, e.g. the 25 MHz pixel enable.
- New divide ratios are applied glitch-free, only at a half-period boundary.

Parameters:
- WIDTH, 32, width of the divide value and of the internal counter.
- DEFAULT_DIV, 2, half-period length in C_100Mhz cycles after reset (2 gives 25 MHz).

Ports:
- C_100Mhz  input  1  system clock, 100 MHz.
- Reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; level-sensitive.
- cfg_valid  input  1  new divide value offered.
- cfg_div  input  WIDTH  half-period length in cycles; 0 is illegal.
- cfg_ready  output  1  controller can accept a configuration this cycle.
- cfg_err  output  1  one-cycle pulse: an accepted cfg_div was 0 and was discarded.
- clk_out  output  1  divided clock level, registered.
- tick  output  1  one-cycle pulse on every clk_out toggle.
- running  output  1  high while in RUN or PEND.

Behaviour:
- Reset state (asynchronous, active-high):
  - state = IDLE, counter = 0, div_active = DEFAULT_DIV, div_pend = 0.
  - clk_out = 0, tick = 0, cfg_err = 0, cfg_ready = 1, running = 0.
- Handshake:
  - A transfer occurs on a rising edge when cfg_valid && cfg_ready.
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND.
  - cfg_ready is derived from the registered state only, never from cfg_valid.
  - A transfer with cfg_div == 0 completes, pulses cfg_err the next cycle, and changes nothing else (no state change).
- Terminal count (TC): counter == div_active-1 while in RUN or PEND with en = 1.
- IDLE:
  - counter held at 0; clk_out holds its level; tick = 0.
  - A legal transfer writes div_active on the next edge.
  - en = 1 -> RUN. If a transfer and the en rise occur in the same cycle, the new value is used from the first RUN cycle.
- RUN:
  - Counter increments each cycle.
  - At TC: clk_out toggles, tick = 1 for that cycle (registered, aligned with the toggle), counter -> 0.
  - A legal transfer -> PEND, with div_pend <= cfg_div.
  - A transfer coinciding with TC still goes to PEND; the current TC completes with the old value.
- PEND:
  - Counts exactly as RUN using the old div_active.
  - At the next TC: toggle and tick as normal, div_active <= div_pend, counter -> 0, -> RUN.
  - The first half-period after that uses the new value.
- en low in RUN or PEND:
  - Next state is IDLE and counter -> 0. There is no toggle and no tick that cycle, even if it was TC (en low has priority).
  - From PEND, div_active <= div_pend on the same edge, so the configuration is not lost.
- Widths and counting:
  - counter is WIDTH bits and never exceeds div_active-1.
  - div_active changes only when counter is reset to 0, so the compare can never be overrun.
  - cfg_div = 1 is legal: clk_out toggles every cycle (50 MHz). Maximum is 2^WIDTH-1.
- Latency: first toggle occurs div_active cycles after the edge on which RUN is entered.
- Reset mid-operation: immediate return to reset values; any pending configuration is lost.
- running is registered and equals (state != IDLE).

Decomposition:
- Shared package gato_clk_pkg holds:
  - the state typedef (IDLE, RUN, PEND);
  - DEFAULT_DIV_25MHZ = 2;
  - DIV_1HZ = 50_000_000, used by the game timer.
- One natural sub-module, div_counter:
  - loadable WIDTH-bit counter with clear, enable and a tc flag;
  - the FSM, handshake and clk_out/tick registers stay in freq_div_ctrl.

Test Plan:
1. Reset then en=1, no config -> first tick 2 cycles after RUN entry; clk_out period 4 cycles (0,0,1,1...); running=1.
2. In RUN with div=2, mid half-period transfer cfg_div=5 -> cfg_ready low; current half-period stays 2 cycles; following half-periods are 5 cycles; cfg_ready returns high the cycle after the boundary.
3. Transfer cfg_div=0 in RUN -> cfg_err pulses exactly 1 cycle; period unchanged at 4 cycles; state stays RUN.
4. en drops on the same cycle as TC -> no toggle, no tick; IDLE next cycle; counter 0; clk_out holds. Re-enable -> first toggle after div_active cycles.
5. In PEND (div_pend=7), drop en -> IDLE with div_active=7. Re-enable -> half-periods of 7 cycles.
6. cfg_div=1 then en=1 -> tick high every cycle, clk_out toggles every cycle. Assert Reset mid-run -> all outputs return to reset values asynchronously; div_active = 2.
